// File: rtl/boost_led_scanner_pkg.sv
// Shared definitions for the boost LED scanner: register map, STATUS layout, scan states.
// Pure declarations; no timing or backpressure of its own.
package boost_led_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_LEVEL  = 2'd1;
  localparam logic [1:0] REG_DWELL  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int ST_SCANNING_BIT = 0;
  localparam int ST_SEL_LSB      = 8;
  localparam int ST_SEL_MSB      = 13;
  localparam int ST_DONE_BIT     = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } scan_state_t;

  // LEVEL is 7 bits wide so it can exceed the bank size; the shadow never does.
  function automatic logic [6:0] clamp_level(input logic [6:0] lvl, input int num_leds);
    return (int'(lvl) > num_leds) ? 7'(num_leds) : lvl;
  endfunction

endpackage

// File: rtl/boost_led_scanner_if.sv
// Avalon-MM slave bus for the scanner register file; readdata is combinational from address.
// No wait states: every access completes in the cycle it is presented.
interface boost_led_scanner_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/boost_led_scanner_slot_timer.sv
// Loadable down-counter with zero flag, shared by the blank and dwell phases.
// Load takes priority over decrement; the count saturates at zero.
module boost_led_slot_timer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        dec,
  output logic        zero
);

  logic [15:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= 16'd0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != 16'd0)) begin
      count <= count - 16'd1;
    end
  end

  assign zero = (count == 16'd0);

endmodule

// File: rtl/boost_led_scanner.sv
// Time-multiplexed LED bank scanner: blank gap then dwell per slot, bar level latched per frame.
// All LED outputs are registered; the CPU bus has zero wait states and zero read latency.
module boost_led_scanner
  import boost_led_pkg::*;
#(
  parameter int NUM_LEDS     = 48,
  parameter int BLANK_CYCLES = 4,
  parameter int DWELL_RESET  = 1000
) (
  input  logic                clk,
  input  logic                reset_n,
  boost_led_scanner_if.slave  bus,
  output logic [5:0]          sel_addr,
  output logic                led_on,
  output logic                frame_pulse
);

  localparam logic [5:0]  LAST_SLOT  = 6'(NUM_LEDS - 1);
  localparam logic [15:0] BLANK_LOAD = 16'(BLANK_CYCLES - 1);

  logic        ctrl_en;
  logic [6:0]  level_reg;
  logic [15:0] dwell_reg;
  logic        frame_done;

  logic        wr;
  logic        ctrl_wr;
  logic        level_wr;
  logic        dwell_wr;
  logic        status_wr;
  logic        en_next;
  logic [15:0] dwell_load;

  scan_state_t state_q, state_d;
  logic [5:0]  sel_d;
  logic        led_d;
  logic        pulse_d;
  logic [6:0]  level_shadow, shadow_d;
  logic        lit;

  logic        tmr_load;
  logic [15:0] tmr_val;
  logic        tmr_dec;
  logic        tmr_zero;

  logic        unused_wdata;

  assign wr        = bus.chipselect && !bus.write_n;
  assign ctrl_wr   = wr && (bus.address == REG_CTRL);
  assign level_wr  = wr && (bus.address == REG_LEVEL);
  assign dwell_wr  = wr && (bus.address == REG_DWELL);
  assign status_wr = wr && (bus.address == REG_STATUS);

  // Looking at the incoming write lets enable/disable act on the very next cycle.
  assign en_next    = ctrl_wr ? bus.writedata[0] : ctrl_en;
  assign dwell_load = (dwell_reg == 16'd0) ? 16'd0 : (dwell_reg - 16'd1);
  assign lit        = ({1'b0, sel_addr} < level_shadow);

  assign unused_wdata = ^bus.writedata[31:17];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_en    <= 1'b0;
      level_reg  <= 7'd0;
      dwell_reg  <= 16'(DWELL_RESET);
      frame_done <= 1'b0;
    end else begin
      if (ctrl_wr)  ctrl_en   <= bus.writedata[0];
      if (level_wr) level_reg <= bus.writedata[6:0];
      if (dwell_wr) dwell_reg <= bus.writedata[15:0];
      // A wrap in the same cycle as a clear write keeps the flag set.
      frame_done <= frame_pulse | (frame_done & ~(status_wr & bus.writedata[ST_DONE_BIT]));
    end
  end

  always_comb begin
    bus.readdata = 32'd0;
    case (bus.address)
      REG_CTRL:   bus.readdata[0]   = ctrl_en;
      REG_LEVEL:  bus.readdata[6:0] = level_reg;
      REG_DWELL:  bus.readdata[15:0] = dwell_reg;
      REG_STATUS: begin
        bus.readdata[ST_SCANNING_BIT]         = (state_q != IDLE);
        bus.readdata[ST_SEL_MSB:ST_SEL_LSB]   = sel_addr;
        bus.readdata[ST_DONE_BIT]             = frame_done;
      end
      default: bus.readdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      sel_addr     <= 6'd0;
      led_on       <= 1'b0;
      frame_pulse  <= 1'b0;
      level_shadow <= 7'd0;
    end else begin
      state_q      <= state_d;
      sel_addr     <= sel_d;
      led_on       <= led_d;
      frame_pulse  <= pulse_d;
      level_shadow <= shadow_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_addr;
    led_d    = 1'b0;
    pulse_d  = 1'b0;
    shadow_d = level_shadow;
    tmr_load = 1'b0;
    tmr_val  = BLANK_LOAD;
    tmr_dec  = 1'b0;

    if (!en_next) begin
      state_d = IDLE;
      sel_d   = 6'd0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d  = BLANK;
          sel_d    = 6'd0;
          tmr_load = 1'b1;
          tmr_val  = BLANK_LOAD;
          shadow_d = clamp_level(level_reg, NUM_LEDS);
        end
        BLANK: begin
          if (tmr_zero) begin
            state_d  = DRIVE;
            tmr_load = 1'b1;
            tmr_val  = dwell_load;
            led_d    = lit;
          end else begin
            tmr_dec = 1'b1;
          end
        end
        DRIVE: begin
          if (tmr_zero) begin
            state_d  = BLANK;
            tmr_load = 1'b1;
            tmr_val  = BLANK_LOAD;
            if (sel_addr == LAST_SLOT) begin
              sel_d    = 6'd0;
              pulse_d  = 1'b1;
              shadow_d = clamp_level(level_reg, NUM_LEDS);
            end else begin
              sel_d = sel_addr + 6'd1;
            end
          end else begin
            tmr_dec = 1'b1;
            led_d   = lit;
          end
        end
        default: begin
          state_d = IDLE;
          sel_d   = 6'd0;
        end
      endcase
    end
  end

  boost_led_slot_timer u_slot_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

endmodule

// File: tb/tb_boost_led_scanner.sv
// Bench for boost_led_scanner: timeline model computed from slot/frame arithmetic.
module tb_boost_led_scanner;

  localparam int N     = 4;
  localparam int BLANK = 2;

  logic       clk;
  logic       reset_n;
  logic [5:0] sel_addr;
  logic       led_on;
  logic       frame_pulse;

  int n_cmp = 0;
  int n_err = 0;

  boost_led_scanner_if bus();

  boost_led_scanner #(
    .NUM_LEDS     (N),
    .BLANK_CYCLES (BLANK),
    .DWELL_RESET  (1000)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .sel_addr    (sel_addr),
    .led_on      (led_on),
    .frame_pulse (frame_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus.address = a;
    #1;
    d = bus.readdata;
  endtask

  task automatic stop_scan();
    wr(2'd0, 32'd0);
    wr(2'd3, 32'h0001_0000);
  endtask

  // Cycle k counts from the first cycle after the enabling write.
  task automatic observe(input string nm, input int ncyc, input int lvl0, input int dwl,
                         input int wk, input logic [1:0] wa, input logic [31:0] wd,
                         input int lvl1);
    int slot_len, frame_len, f, slot, k_in, lv, exp_sel;
    logic exp_led, exp_pls;
    slot_len  = BLANK + ((dwl == 0) ? 1 : dwl);
    frame_len = N * slot_len;
    for (int k = 0; k < ncyc; k++) begin
      if (k == wk + 1) begin
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
      end
      f    = k / frame_len;
      slot = (k % frame_len) / slot_len;
      k_in = k % slot_len;
      lv   = (wa == 2'd1 && wk >= 0 && wk < f * frame_len - 1) ? lvl1 : lvl0;
      if (lv > N) lv = N;
      exp_sel = slot;
      exp_led = (k_in >= BLANK) && (slot < lv);
      exp_pls = (k > 0) && (k % frame_len == 0);
      n_cmp++;
      if (sel_addr !== 6'(exp_sel)) begin
        n_err++;
        $display("FAIL %s k=%0d sel_addr got %0d want %0d", nm, k, sel_addr, exp_sel);
      end
      n_cmp++;
      if (led_on !== exp_led) begin
        n_err++;
        $display("FAIL %s k=%0d led_on got %b want %b", nm, k, led_on, exp_led);
      end
      n_cmp++;
      if (frame_pulse !== exp_pls) begin
        n_err++;
        $display("FAIL %s k=%0d frame_pulse got %b want %b", nm, k, frame_pulse, exp_pls);
      end
      if (k == wk) begin
        bus.address = wa; bus.writedata = wd; bus.chipselect = 1'b1; bus.write_n = 1'b0;
      end
      @(negedge clk);
    end
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic check_idle_outputs(input string nm);
    n_cmp++;
    if (sel_addr !== 6'd0 || led_on !== 1'b0 || frame_pulse !== 1'b0) begin
      n_err++;
      $display("FAIL %s outputs got sel=%0d led=%b pulse=%b want 0/0/0",
               nm, sel_addr, led_on, frame_pulse);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [31:0] exp_regs [4];
    exp_regs = '{32'd0, 32'd0, 32'd1000, 32'd0};
    reset_n = 1'b0;
    bus.address = 2'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = 32'd0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), d);
      n_cmp++;
      if (d !== exp_regs[a]) begin
        n_err++;
        $display("FAIL reset_reg%0d got %h want %h", a, d, exp_regs[a]);
      end
    end
    check_idle_outputs("reset");
  endtask

  task automatic test_basic();
    logic [31:0] d;
    wr(2'd1, 32'd2);
    wr(2'd2, 32'd3);
    wr(2'd0, 32'd1);
    observe("basic", 40, 2, 3, -1, 2'd0, 32'd0, 0);
    rd(2'd3, d);
    n_cmp++;
    if (d !== 32'h0001_0001) begin
      n_err++;
      $display("FAIL basic_status got %h want %h", d, 32'h0001_0001);
    end
    stop_scan();
  endtask

  task automatic test_level_midframe();
    wr(2'd1, 32'd1);
    wr(2'd2, 32'd3);
    wr(2'd0, 32'd1);
    observe("lvl_mid", 40, 1, 3, 7, 2'd1, 32'd4, 4);
    stop_scan();
  endtask

  task automatic test_dwell_zero();
    logic [31:0] d;
    wr(2'd1, 32'd70);
    wr(2'd2, 32'd0);
    wr(2'd0, 32'd1);
    observe("dwell0", 2 * N * (BLANK + 1), 70, 0, -1, 2'd0, 32'd0, 0);
    rd(2'd1, d);
    n_cmp++;
    if (d !== 32'd70) begin
      n_err++;
      $display("FAIL level_readback got %0d want 70", d);
    end
    stop_scan();
  endtask

  task automatic test_random();
    int lv0, lv1, dw, fl, wk;
    for (int it = 0; it < 6; it++) begin
      lv0 = $urandom_range(0, 70);
      lv1 = $urandom_range(0, 70);
      dw  = $urandom_range(0, 6);
      fl  = N * (BLANK + ((dw == 0) ? 1 : dw));
      wk  = $urandom_range(1, fl - 3);
      wr(2'd1, 32'(lv0));
      wr(2'd2, 32'(dw));
      wr(2'd0, 32'd1);
      observe("random", 2 * fl + 1, lv0, dw, wk, 2'd1, 32'(lv1), lv1);
      stop_scan();
    end
  endtask

  task automatic test_disable();
    logic [31:0] d;
    wr(2'd1, 32'd4);
    wr(2'd2, 32'd3);
    wr(2'd0, 32'd1);
    observe("dis_run", 14, 4, 3, 13, 2'd0, 32'd0, 0);
    check_idle_outputs("dis_next");
    rd(2'd3, d);
    n_cmp++;
    if (d !== 32'd0) begin
      n_err++;
      $display("FAIL dis_status got %h want 0", d);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle_outputs("dis_hold");
    end
    wr(2'd0, 32'd1);
    observe("reenable", 20, 4, 3, -1, 2'd0, 32'd0, 0);
    stop_scan();
  endtask

  task automatic test_clear_collision();
    logic [31:0] d;
    wr(2'd1, 32'd2);
    wr(2'd2, 32'd1);
    wr(2'd0, 32'd1);
    observe("coll", 13, 2, 1, 12, 2'd3, 32'h0001_0000, 0);
    rd(2'd3, d);
    n_cmp++;
    if (d[16] !== 1'b1) begin
      n_err++;
      $display("FAIL coll_done got %b want 1", d[16]);
    end
    wr(2'd3, 32'h0001_0000);
    rd(2'd3, d);
    n_cmp++;
    if (d[16] !== 1'b0) begin
      n_err++;
      $display("FAIL clear_done got %b want 0", d[16]);
    end
    stop_scan();
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    wr(2'd1, 32'd4);
    wr(2'd2, 32'd3);
    wr(2'd0, 32'd1);
    observe("pre_rst", 8, 4, 3, -1, 2'd0, 32'd0, 0);
    #2 reset_n = 1'b0;
    #1;
    check_idle_outputs("async_rst");
    rd(2'd0, d);
    n_cmp++;
    if (d !== 32'd0) begin
      n_err++;
      $display("FAIL rst_ctrl got %h want 0", d);
    end
    rd(2'd2, d);
    n_cmp++;
    if (d !== 32'd1000) begin
      n_err++;
      $display("FAIL rst_dwell got %0d want 1000", d);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("post_rst");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_level_midframe();
    test_dwell_zero();
    test_disable();
    test_clear_collision();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
